uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, runtime baud divisor, optional parity and 1 or 2 stop bits. It sits between a streaming valid/ready byte source (CPU register bank or DMA) and the serial TX pin. Queued words are sent as back-to-back frames with no idle gap. This block replaces single-byte, fixed-format transmit for links that need 5–9 data bits and parity.

## Interface
- CLK_HZ, 50_000_000: clock frequency; with BIT_RATE, gives the default divisor CLK_HZ/BIT_RATE.
- BIT_RATE, 9600: default bit rate, used when baud_div == 0.
- PAYLOAD_BITS, 8: data bits per frame, legal range 5..9.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY, 0: parity mode, 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH, 4: FIFO entries, power of two, at least 2.
- DIV_W, 16: width of baud_div.
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  source has a word.
- s_ready  out  1  FIFO can accept; equals (fifo_level < FIFO_DEPTH).
- s_data  in  PAYLOAD_BITS  word to send.
- baud_div  in  DIV_W  clocks per bit; 0 selects the default divisor.
- uart_txd  out  1  serial line, registered, idles high.
- tx_busy  out  1  high when state != IDLE or fifo_level != 0.
- frame_done  out  1  one-cycle pulse on the last clock of each frame's final stop bit.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of queued words.

## Operation
- Push happens when s_valid && s_ready. A push while full cannot occur, because s_ready is low.
- Simultaneous push and pop when not full: fifo_level is unchanged and order is preserved. FIFO pointers wrap modulo FIFO_DEPTH.
- The state machine has five states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - uart_txd = 1.
  - When fifo_level > 0: pop the head into the shift register, latch D = (baud_div == 0 ? CLK_HZ/BIT_RATE : baud_div), then go to START.
- START: uart_txd = 0 for D clocks, then go to DATA.
- DATA:
  - Send PAYLOAD_BITS bits, LSB first, each for D clocks.
  - Then go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY:
  - Even mode sends the XOR of the data bits. Odd mode sends the inverse of that XOR.
  - Hold the bit for D clocks, then go to STOP.
- STOP:
  - uart_txd = 1 for STOP_BITS × D clocks.
  - On the final clock, pulse frame_done.
  - If the FIFO is non-empty on that final clock, pop and go directly to START with a newly latched D. Otherwise go to IDLE.
- Baud handling:
  - D is latched once per frame; changes to baud_div mid-frame have no effect on the current frame.
  - baud_div = 1 is legal and gives one clock per bit.
  - The bit counter and baud counter are sized to hold PAYLOAD_BITS and D−1 with no truncation.
- Reset, including reset asserted mid-frame, immediately forces:
  - state = IDLE, uart_txd = 1
  - FIFO flushed, fifo_level = 0, s_ready = 1
  - tx_busy = 0, frame_done = 0

## Timing
- Pop latency: a word pushed in cycle t makes fifo_level = 1 in cycle t+1. If the FIFO is idle, it is popped in t+1, and uart_txd = 0 from cycle t+2.
- Frame length is exactly (1 + PAYLOAD_BITS + (PARITY != 0) + STOP_BITS) × D clocks.
- Back-to-back frames:
  - The start bit of frame n+1 follows the last stop-bit clock of frame n directly, with zero idle clocks.
  - frame_done for frame n coincides with that final stop-bit clock.
- s_ready, tx_busy and fifo_level update on the clock after the push or pop that changes them.

## Test plan
- **Basic frame.** PARITY=0, STOP_BITS=1, baud_div=4, push 0x55 → uart_txd sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks (40 clocks total); frame_done pulses once on clock 40; then IDLE with tx_busy = 0.
- **Parity and 2 stop bits.** PARITY=1, baud_div=4, push 0x07 → parity bit 1. PARITY=2 with the same input → parity bit 0. STOP_BITS=2 → line high for 8 clocks before IDLE.
- **FIFO full and order.** FIFO_DEPTH=4, baud_div=4, push 6 words 0xA0..0xA5 on consecutive cycles →
  - s_ready drops with fifo_level = 4;
  - the 6th word is accepted only after frame 1 pops;
  - all 6 words are emitted in order with no idle clocks between frames, and exactly 6 frame_done pulses occur.
- **Divisor change mid-frame.** Start a frame with baud_div=4, set baud_div=8 during DATA → the current frame keeps 4-clock bits; the next queued frame uses 8-clock bits. baud_div=0 → bits last CLK_HZ/BIT_RATE clocks.
- **Reset mid-frame.** Assert resetn low during DATA with 3 words queued → uart_txd = 1 and fifo_level = 0 immediately. After release: s_ready = 1, no further frames are sent, and a new push transmits normally.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: runtime baud divisor, optional parity,
// 1 or 2 stop bits, back-to-back frames with no idle gap between queued words.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DIV_W        = 16
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [PAYLOAD_BITS-1:0]              s_data,
    input  logic [DIV_W-1:0]                     baud_div,
    output logic                                 uart_txd,
    output logic                                 tx_busy,
    output logic                                 frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

    localparam int unsigned DEF_DIV = CLK_HZ / BIT_RATE;
    localparam int unsigned DEF_W   = $clog2(DEF_DIV + 1);
    localparam int unsigned CNT_W   = (DIV_W > DEF_W) ? DIV_W : DEF_W;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W   = $clog2(PAYLOAD_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                  state_q, state_d;
    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    par_q, par_d;
    logic [CNT_W-1:0]        div_q, div_d, cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;

    logic                    push, pop, bit_end;
    logic [PAYLOAD_BITS-1:0] head;

    assign push    = s_valid && ready_q;
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (cnt_q == div_q - CNT_W'(1));

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        par_d    = par_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(PAYLOAD_BITS - 1)) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Divisor and parity are captured once per frame at pop time
        if (pop) begin
            shift_d = head;
            par_d   = (^head) ^ (PARITY == 2);
            div_d   = (baud_div == '0) ? CNT_W'(DEF_DIV) : CNT_W'(baud_div);
            cnt_d   = '0;
            bit_d   = '0;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase

        busy_d  = (state_d != S_IDLE) || (level_d != '0);
        ready_d = (level_d < LVL_W'(FIFO_DEPTH));
        done_d  = (state_d == S_STOP) && (cnt_d == div_d - CNT_W'(1))
                  && (bit_d == BIT_W'(STOP_BITS - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            div_q    <= CNT_W'(1);
            cnt_q    <= '0;
            bit_q    <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign uart_txd   = txd_q;
    assign tx_busy    = busy_q;
    assign frame_done = done_q;
    assign s_ready    = ready_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (no parity/1 stop,
// even/2 stop, odd/1 stop) sharing stimulus, default divisor of 10 clocks.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic       s_valid;
    logic [7:0] s_data;
    logic [15:0] baud_div;
    logic [2:0] rdy, txd, busy, fd;
    logic [2:0] lvl [3];

    int checks = 0;
    int errors = 0;
    int fd_cnt0 = 0;
    int fd_base;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(1000), .BIT_RATE(100), .PAYLOAD_BITS(8), .STOP_BITS(1),
                   .PARITY(0), .FIFO_DEPTH(4), .DIV_W(16)) dut0 (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(rdy[0]),
        .s_data(s_data), .baud_div(baud_div), .uart_txd(txd[0]),
        .tx_busy(busy[0]), .frame_done(fd[0]), .fifo_level(lvl[0]));

    uart_tx_fifo #(.CLK_HZ(1000), .BIT_RATE(100), .PAYLOAD_BITS(8), .STOP_BITS(2),
                   .PARITY(1), .FIFO_DEPTH(4), .DIV_W(16)) dut1 (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(rdy[1]),
        .s_data(s_data), .baud_div(baud_div), .uart_txd(txd[1]),
        .tx_busy(busy[1]), .frame_done(fd[1]), .fifo_level(lvl[1]));

    uart_tx_fifo #(.CLK_HZ(1000), .BIT_RATE(100), .PAYLOAD_BITS(8), .STOP_BITS(1),
                   .PARITY(2), .FIFO_DEPTH(4), .DIV_W(16)) dut2 (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(rdy[2]),
        .s_data(s_data), .baud_div(baud_div), .uart_txd(txd[2]),
        .tx_busy(busy[2]), .frame_done(fd[2]), .fifo_level(lvl[2]));

    always @(negedge clk) if (fd[0]) fd_cnt0++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        resetn  = 1'b0;
        @(negedge clk);
        resetn  = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start(input int sel, input string tag);
        int n = 0;
        while (txd[sel] !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check({tag, "_start_timeout"}, 1, 0);
    endtask

    // Called on the negedge of the start bit's first clock; returns on the
    // negedge just after the frame's last stop clock.
    task automatic expect_frame(input int sel, input logic [7:0] data, input int par_bit,
                                input int nstop, input int d, input string tag);
        logic bits [$];
        int   fd_bad = 0;
        int   obs;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (par_bit >= 0) bits.push_back(par_bit[0]);
        for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
        foreach (bits[k]) begin
            obs = int'(bits[k]);
            for (int c = 0; c < d; c++) begin
                if (txd[sel] !== bits[k]) obs = int'(txd[sel]);
                if (fd[sel] !== ((k == bits.size() - 1) && (c == d - 1))) fd_bad++;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, k), obs, int'(bits[k]));
        end
        check({tag, "_frame_done"}, fd_bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_low;
        resetn   = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        baud_div = 16'd4;
        repeat (3) @(negedge clk);
        check("rst_txd",   int'(txd[0]),  1);
        check("rst_level", int'(lvl[0]),  0);
        check("rst_ready", int'(rdy[0]),  1);
        check("rst_busy",  int'(busy[0]), 0);
        check("rst_done",  int'(fd[0]),   0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic frame 0x55 (even parity 0, odd parity 1)
        fd_base = fd_cnt0;
        push(8'h55);
        check("pop_lat_level", int'(lvl[0]),  1);
        check("pop_lat_busy",  int'(busy[0]), 1);
        check("pop_lat_txd",   int'(txd[0]),  1);
        @(negedge clk);
        fork
            expect_frame(0, 8'h55, -1, 1, 4, "basic");
            expect_frame(1, 8'h55,  0, 2, 4, "even55");
            expect_frame(2, 8'h55,  1, 1, 4, "odd55");
        join
        check("basic_idle_busy0", int'(busy[0]), 0);
        check("basic_idle_busy1", int'(busy[1]), 0);
        check("basic_idle_busy2", int'(busy[2]), 0);
        check("basic_done_count", fd_cnt0 - fd_base, 1);

        // 0x07: even parity 1, odd parity 0, two stop bits on dut1
        push(8'h07);
        @(negedge clk);
        fork
            expect_frame(0, 8'h07, -1, 1, 4, "plain07");
            expect_frame(1, 8'h07,  1, 2, 4, "even07");
            expect_frame(2, 8'h07,  0, 1, 4, "odd07");
        join
        check("par_idle_busy1", int'(busy[1]), 0);

        // FIFO full, ordering, back-to-back frames
        do_reset();
        fd_base = fd_cnt0;
        fork
            begin
                int cyc = 0;
                int acc_cyc = -1;
                for (int i = 0; i < 6; i++) begin
                    s_valid = 1'b1;
                    s_data  = 8'(8'hA0 + i);
                    if (i == 5) begin
                        check("full_level", int'(lvl[0]), 4);
                        check("full_ready", int'(rdy[0]), 0);
                    end
                    while (rdy[0] !== 1'b1 && cyc < 200) begin
                        @(negedge clk);
                        cyc++;
                    end
                    if (i == 5) acc_cyc = cyc;
                    @(negedge clk);
                    cyc++;
                end
                s_valid = 1'b0;
                check("sixth_accept_cycle", acc_cyc, 42);
            end
            begin
                wait_start(0, "fifo");
                for (int i = 0; i < 6; i++)
                    expect_frame(0, 8'(8'hA0 + i), -1, 1, 4, $sformatf("fifo%0d", i));
            end
        join
        check("fifo_done_count", fd_cnt0 - fd_base, 6);
        check("fifo_idle_busy", int'(busy[0]), 0);
        check("fifo_idle_level", int'(lvl[0]), 0);

        // Divisor change mid-frame, then default divisor
        do_reset();
        baud_div = 16'd4;
        push(8'h3C);
        push(8'hC3);
        fork
            begin
                repeat (8) @(negedge clk);
                baud_div = 16'd8;
            end
            begin
                expect_frame(0, 8'h3C, -1, 1, 4, "div4");
                expect_frame(0, 8'hC3, -1, 1, 8, "div8");
            end
        join
        baud_div = 16'd0;
        push(8'h96);
        @(negedge clk);
        expect_frame(0, 8'h96, -1, 1, 10, "divdef");

        // Reset in the middle of a frame with three words queued
        do_reset();
        baud_div = 16'd4;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        check("pre_rst_level", int'(lvl[0]), 3);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_txd",   int'(txd[0]),  1);
        check("midrst_level", int'(lvl[0]),  0);
        check("midrst_ready", int'(rdy[0]),  1);
        check("midrst_busy",  int'(busy[0]), 0);
        check("midrst_done",  int'(fd[0]),   0);
        @(negedge clk);
        resetn  = 1'b1;
        fd_base = fd_cnt0;
        seen_low = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd[0] !== 1'b1) seen_low++;
        end
        check("postrst_quiet_txd",  seen_low, 0);
        check("postrst_done_count", fd_cnt0 - fd_base, 0);
        check("postrst_ready",      int'(rdy[0]),  1);
        check("postrst_level",      int'(lvl[0]),  0);
        check("postrst_busy",       int'(busy[0]), 0);
        push(8'h5A);
        @(negedge clk);
        expect_frame(0, 8'h5A, -1, 1, 4, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
